bus_transfer_controller: RTL and testbench
==========================================

Name: bus_transfer_controller

Overview:
Sequences register-to-register moves over the shared 32-bit tristate bus. Each register on the bus is controlled by an input_enable/output_enable pair. Up to NREQ requesters (control unit, debug port, etc.) post (src, dst) transfer requests. The block arbitrates round-robin, then drives the one-hot output/input enables so that exactly one register drives the bus and one register captures it.

Parameters:
NREQ, 4, number of requesters
NREG, 8, number of bus registers controlled
SELW, 3, register index width (ceil log2 NREG)
CNTW, 16, width of completed-transfer counter

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-low reset (0 = clear)
req  input  NREQ  per-requester request level
src_sel  input  NREQ*SELW  source index, requester i at bits [i*SELW +: SELW]
dst_sel  input  NREQ*SELW  destination index, same packing
grant  output  NREQ  one-hot grant to the requester being served
done  output  1  one-cycle pulse: granted transfer finished
err  output  1  one-cycle pulse with done: transfer rejected
out_en  output  NREG  per-register output_enable (bus drive)
in_en  output  NREG  per-register input_enable (capture)
busy  output  1  high whenever state != IDLE
xfer_count  output  CNTW  number of successful transfers

Behaviour:
- All outputs are registered.
- clr low asynchronously forces state=IDLE, rr pointer=0, and grant, done, err, out_en, in_en, busy, xfer_count all to 0. Outputs stay 0 while clr is low.
- FSM states: IDLE, DRIVE, LATCH, DONE.
- IDLE, req==0: stay in IDLE, all outputs 0.
- IDLE, req!=0: winner = first set bit of req, searching upward from rr pointer with wrap. Latch src and dst from the winner's fields. Assert grant[winner] and go to DRIVE.
  - Exception: if src==dst, or either index >= NREG, go to DONE with err set.
- DRIVE (1 cycle): out_en[src]=1 only, so the bus settles.
- LATCH (1 cycle): out_en[src]=1 and in_en[dst]=1. The destination captures on the rising edge that ends LATCH.
- DONE (1 cycle): out_en=0, in_en=0, done=1, grant held.
  - xfer_count increments (wraps at 2^CNTW) only if err=0.
  - rr pointer becomes (winner+1) mod NREQ.
  - Next state is IDLE.
- grant is high from DRIVE through DONE and drops in IDLE.
- Valid transfer: 4 cycles from the IDLE sample to the next IDLE. Rejected transfer: 2 cycles (IDLE, DONE).
- A req still high in the next IDLE is re-arbitrated; the rotated pointer guarantees fairness.
- Invariants, checked every cycle:
  - popcount(out_en) <= 1, so there is never bus contention.
  - popcount(in_en) <= 1.
  - in_en is only set in LATCH.
  - out_en and in_en never share a set bit.
- Requester fields and req are sampled only in IDLE. Changes or deassertion mid-transfer are ignored and the transfer completes.
- A requester must hold req until it sees done with its grant bit set; otherwise the transfer may be lost.
- clr low during LATCH: enables drop immediately. Whether dst captures is undefined, but no spurious done is produced.

Test Plan:
- Basic move: preload R2=24, R5=0. req=0001, src0=2, dst0=5 → grant=0001 for 3 cycles; out_en=00000100 in DRIVE and LATCH; in_en=00100000 in LATCH only; done pulse in cycle 4; R5=24; xfer_count=1.
- Round-robin: req=1111 held, all fields valid and distinct → grant order 0001, 0010, 0100, 1000, 0001; done every 4 cycles; xfer_count=4 after 16 cycles.
- Reject: src0=dst0=3 → grant 0001; done=1 and err=1 in the second cycle; out_en and in_en stay 0; xfer_count unchanged.
- Mid-transfer change: start 1→6, then change src0 to 4 and drop req in DRIVE → out_en stays 00000010; R6 gets R1's value; done pulses once.
- Reset mid-op: clr=0 in LATCH → out_en, in_en, grant, busy go 0 without waiting for a clock edge; after clr=1 and req=0100 → grant=0100 (pointer reset to 0, lowest set bit wins); xfer_count=0.
- Contention monitor: run 1000 random requests → popcount(out_en) <= 1 and popcount(in_en) <= 1 every cycle; xfer_count equals the number of non-err done pulses.

Source files
------------

// File: rtl/bus_transfer_controller_if.sv
// Request and enable bundle shared by the bus requesters and the transfer controller.
// The controller connects through the slave modport; requesters use master.
interface bus_transfer_controller_if #(
    parameter int NREQ = 4,
    parameter int NREG = 8,
    parameter int SELW = 3,
    parameter int CNTW = 16
);
    logic [NREQ-1:0]      req;
    logic [NREQ*SELW-1:0] src_sel;
    logic [NREQ*SELW-1:0] dst_sel;
    logic [NREQ-1:0]      grant;
    logic                 done;
    logic                 err;
    logic [NREG-1:0]      out_en;
    logic [NREG-1:0]      in_en;
    logic                 busy;
    logic [CNTW-1:0]      xfer_count;

    modport master (
        output req, src_sel, dst_sel,
        input  grant, done, err, out_en, in_en, busy, xfer_count
    );

    modport slave (
        input  req, src_sel, dst_sel,
        output grant, done, err, out_en, in_en, busy, xfer_count
    );
endinterface

// File: rtl/bus_transfer_controller.sv
// Round-robin sequencer for register-to-register moves over a shared tristate bus:
// one register drives (out_en) for two cycles, one register captures (in_en) in the second.
module bus_transfer_controller #(
    parameter int NREQ = 4,
    parameter int NREG = 8,
    parameter int SELW = 3,
    parameter int CNTW = 16
) (
    input  logic                     clk,
    input  logic                     clr,
    bus_transfer_controller_if.slave bus
);
    localparam int PTRW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PTRW1 = PTRW + 1;

    typedef enum logic [1:0] {IDLE, DRIVE, LATCH, DONE} state_t;

    state_t          state;
    logic [PTRW-1:0] rr_ptr;
    logic [PTRW-1:0] win_q;
    logic [NREG-1:0] dst_oh_q;

    logic [NREQ-1:0] rot;
    logic [PTRW-1:0] off;
    logic [PTRW:0]   win_sum;
    logic [PTRW-1:0] win;
    logic [SELW-1:0] src_w;
    logic [SELW-1:0] dst_w;
    logic [NREG-1:0] src_oh;
    logic [NREG-1:0] dst_oh;
    logic            reject;

    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        // Rotate so the rr pointer sits at bit 0; the lowest set bit is then the winner's offset.
        rot = NREQ'({bus.req, bus.req} >> rr_ptr);
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) off = PTRW'(k);
        end
        win_sum = {1'b0, rr_ptr} + {1'b0, off};
        win     = (win_sum >= PTRW1'(NREQ)) ? PTRW'(win_sum - PTRW1'(NREQ)) : PTRW'(win_sum);

        src_w = '0;
        dst_w = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win == PTRW'(k)) begin
                src_w = bus.src_sel[k*SELW +: SELW];
                dst_w = bus.dst_sel[k*SELW +: SELW];
            end
        end

        // An index past the last register shifts the one-hot out entirely, flagging it invalid.
        src_oh = NREG'(1) << src_w;
        dst_oh = NREG'(1) << dst_w;
        reject = (src_oh == '0) || (dst_oh == '0) || (src_w == dst_w);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            // NOTE: the winner and destination latches are reset too; they are a few flops
            // and this keeps every output X-free straight out of reset.
            win_q          <= '0;
            dst_oh_q       <= '0;
            bus.grant      <= '0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.out_en     <= '0;
            bus.in_en      <= '0;
            bus.busy       <= 1'b0;
            bus.xfer_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        win_q     <= win;
                        bus.grant <= NREQ'(1) << win;
                        bus.busy  <= 1'b1;
                        if (reject) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                            bus.err  <= 1'b1;
                        end else begin
                            state      <= DRIVE;
                            bus.out_en <= src_oh;
                            dst_oh_q   <= dst_oh;
                        end
                    end
                end
                DRIVE: begin
                    state     <= LATCH;
                    bus.in_en <= dst_oh_q;
                end
                LATCH: begin
                    state          <= DONE;
                    bus.out_en     <= '0;
                    bus.in_en      <= '0;
                    bus.done       <= 1'b1;
                    bus.xfer_count <= bus.xfer_count + 1'b1;
                end
                DONE: begin
                    state     <= IDLE;
                    bus.done  <= 1'b0;
                    bus.err   <= 1'b0;
                    bus.grant <= '0;
                    bus.busy  <= 1'b0;
                    rr_ptr    <= (win_q == PTRW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_transfer_controller.sv
// Bench for bus_transfer_controller: a transaction-level model predicts every output cycle,
// directed scenarios pin literal values, and a random requester phase stresses arbitration.
module tb_bus_transfer_controller;
    localparam int NREQ = 4;
    localparam int NREG = 8;
    localparam int SELW = 3;
    localparam int CNTW = 16;
    localparam int FW   = NREQ * SELW;
    localparam logic [31:0] R1_VAL = 32'hA5A5_0001;

    logic clk;
    logic clr;
    int   checks   = 0;
    int   errors   = 0;
    int   ok_dones = 0;

    bus_transfer_controller_if #(.NREQ(NREQ), .NREG(NREG), .SELW(SELW), .CNTW(CNTW)) bus ();

    bus_transfer_controller #(.NREQ(NREQ), .NREG(NREG), .SELW(SELW), .CNTW(CNTW)) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic bit_at(input logic [NREQ-1:0] v, input int i);
        logic [NREQ-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic en_at(input logic [NREG-1:0] v, input int i);
        logic [NREG-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [SELW-1:0] field(input logic [FW-1:0] v, input int i);
        logic [FW-1:0] t;
        t = v >> (i * SELW);
        return t[SELW-1:0];
    endfunction

    task automatic set_req(input int i, input logic [SELW-1:0] s, input logic [SELW-1:0] d);
        logic [FW-1:0] mask;
        mask        = FW'({SELW{1'b1}}) << (i * SELW);
        bus.src_sel = (bus.src_sel & ~mask) | (FW'(s) << (i * SELW));
        bus.dst_sel = (bus.dst_sel & ~mask) | (FW'(d) << (i * SELW));
        bus.req     = bus.req | (NREQ'(1) << i);
    endtask

    task automatic drop_req(input int i);
        bus.req = bus.req & ~(NREQ'(1) << i);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 clr = 1'b0;
        @(negedge clk);
        #2 clr = 1'b1;
        @(negedge clk);
    endtask

    // Bus registers living outside the controller; the enables decide who drives and who captures.
    logic [31:0] regs [NREG];
    logic [31:0] bus_val;

    always_comb begin
        bus_val = '0;
        for (int i = 0; i < NREG; i++) begin
            if (en_at(bus.out_en, i)) bus_val = bus_val | regs[i];
        end
    end

    initial begin
        for (int i = 0; i < NREG; i++) regs[i] = 32'(i) * 32'h1111_1111;
        regs[1] = R1_VAL;
        regs[2] = 32'd24;
        regs[5] = 32'd0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < NREG; i++) begin
                if (en_at(bus.in_en, i)) regs[i] = bus_val;
            end
        end
    end

    // Expected outputs for one cycle.
    typedef struct packed {
        logic [NREQ-1:0] grant;
        logic            done;
        logic            err;
        logic [NREG-1:0] out_en;
        logic [NREG-1:0] in_en;
        logic            busy;
        logic [CNTW-1:0] cnt;
    } exp_t;

    function automatic exp_t mk(input logic [NREQ-1:0] g, input logic dn, input logic er,
                                input logic [NREG-1:0] oe, input logic [NREG-1:0] ie,
                                input logic bz, input logic [CNTW-1:0] c);
        exp_t e;
        e.grant  = g;
        e.done   = dn;
        e.err    = er;
        e.out_en = oe;
        e.in_en  = ie;
        e.busy   = bz;
        e.cnt    = c;
        return e;
    endfunction

    // Transaction model: an accepted request expands into the list of cycles it will occupy.
    exp_t            exp_now;
    exp_t            plan[$];
    int              ptr;
    logic [CNTW-1:0] mcount;

    initial begin
        exp_now = '0;
        ptr     = 0;
        mcount  = '0;
        forever begin
            @(posedge clk or negedge clr);
            if (!clr) begin
                plan.delete();
                ptr     = 0;
                mcount  = '0;
                exp_now = '0;
            end else if (exp_now.busy) begin
                if (plan.size() > 0) exp_now = plan.pop_front();
                else exp_now = mk('0, 1'b0, 1'b0, '0, '0, 1'b0, mcount);
            end else if (bus.req != '0) begin
                int              w;
                logic [SELW-1:0] s;
                logic [SELW-1:0] d;
                logic [NREQ-1:0] g;
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && bit_at(bus.req, (ptr + k) % NREQ)) w = (ptr + k) % NREQ;
                end
                s   = field(bus.src_sel, w);
                d   = field(bus.dst_sel, w);
                g   = NREQ'(1) << w;
                ptr = (w + 1) % NREQ;
                if (s == d || int'(s) >= NREG || int'(d) >= NREG) begin
                    plan.push_back(mk(g, 1'b1, 1'b1, '0, '0, 1'b1, mcount));
                end else begin
                    plan.push_back(mk(g, 1'b0, 1'b0, NREG'(1) << s, '0, 1'b1, mcount));
                    plan.push_back(mk(g, 1'b0, 1'b0, NREG'(1) << s, NREG'(1) << d, 1'b1, mcount));
                    mcount = mcount + 1'b1;
                    plan.push_back(mk(g, 1'b1, 1'b0, '0, '0, 1'b1, mcount));
                end
                exp_now = plan.pop_front();
            end else begin
                exp_now = mk('0, 1'b0, 1'b0, '0, '0, 1'b0, mcount);
            end
        end
    end

    // Per-cycle comparison against the model plus the bus-safety invariants.
    initial begin
        forever begin
            @(negedge clk);
            if (clr) begin
                check("grant",      32'(bus.grant),      32'(exp_now.grant));
                check("done",       32'(bus.done),       32'(exp_now.done));
                check("err",        32'(bus.err),        32'(exp_now.err));
                check("out_en",     32'(bus.out_en),     32'(exp_now.out_en));
                check("in_en",      32'(bus.in_en),      32'(exp_now.in_en));
                check("busy",       32'(bus.busy),       32'(exp_now.busy));
                check("xfer_count", 32'(bus.xfer_count), 32'(exp_now.cnt));
                check("out_en_onehot", 32'($countones(bus.out_en) <= 1), 32'd1);
                check("in_en_onehot",  32'($countones(bus.in_en) <= 1),  32'd1);
                check("en_overlap",    32'(bus.out_en & bus.in_en),      32'd0);
                if (bus.done && !bus.err) ok_dones++;
            end
        end
    end

    logic [NREQ-1:0] gexp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        logic [NREQ-1:0] pend;
        int              issued;
        int              cyc;

        clr         = 1'b1;
        bus.req     = '0;
        bus.src_sel = '0;
        bus.dst_sel = '0;
        #1 clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant",  32'(bus.grant),      32'd0);
        check("rst_out_en", 32'(bus.out_en),     32'd0);
        check("rst_busy",   32'(bus.busy),       32'd0);
        check("rst_count",  32'(bus.xfer_count), 32'd0);
        #2 clr = 1'b1;

        // Basic move R2 -> R5.
        @(negedge clk);
        set_req(0, 3'd2, 3'd5);
        @(negedge clk);
        check("basic_drive_grant",  32'(bus.grant),  32'h01);
        check("basic_drive_out_en", 32'(bus.out_en), 32'h04);
        check("basic_drive_in_en",  32'(bus.in_en),  32'h00);
        @(negedge clk);
        check("basic_latch_out_en", 32'(bus.out_en), 32'h04);
        check("basic_latch_in_en",  32'(bus.in_en),  32'h20);
        @(negedge clk);
        check("basic_done",   32'(bus.done),       32'd1);
        check("basic_err",    32'(bus.err),        32'd0);
        check("basic_grant3", 32'(bus.grant),      32'h01);
        check("basic_count",  32'(bus.xfer_count), 32'd1);
        drop_req(0);
        @(negedge clk);
        check("basic_idle_grant", 32'(bus.grant), 32'd0);
        check("basic_r5",         regs[5],        32'd24);

        // Round robin with all four requesters held.
        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, SELW'(i), SELW'(i + 4));
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("rr_grant", 32'(bus.grant), 32'(gexp[t]));
            @(negedge clk);
            @(negedge clk);
            check("rr_done", 32'(bus.done), 32'd1);
            if (t == 3) check("rr_count4", 32'(bus.xfer_count), 32'd4);
            if (t == 4) bus.req = '0;
            @(negedge clk);
        end

        // Rejected transfer: src == dst.
        pulse_reset();
        set_req(0, 3'd3, 3'd3);
        @(negedge clk);
        check("rej_grant",  32'(bus.grant),      32'h01);
        check("rej_done",   32'(bus.done),       32'd1);
        check("rej_err",    32'(bus.err),        32'd1);
        check("rej_out_en", 32'(bus.out_en),     32'd0);
        check("rej_in_en",  32'(bus.in_en),      32'd0);
        check("rej_count",  32'(bus.xfer_count), 32'd0);
        drop_req(0);
        @(negedge clk);
        check("rej_idle_busy", 32'(bus.busy),       32'd0);
        check("rej_idle_cnt",  32'(bus.xfer_count), 32'd0);

        // Fields change and req drops mid-transfer; the sampled move R1 -> R6 still completes.
        set_req(0, 3'd1, 3'd6);
        @(negedge clk);
        check("mid_drive_out_en", 32'(bus.out_en), 32'h02);
        bus.src_sel = (bus.src_sel & ~FW'(7)) | FW'(4);
        drop_req(0);
        @(negedge clk);
        check("mid_latch_out_en", 32'(bus.out_en), 32'h02);
        check("mid_latch_in_en",  32'(bus.in_en),  32'h40);
        @(negedge clk);
        check("mid_done",  32'(bus.done),       32'd1);
        check("mid_count", 32'(bus.xfer_count), 32'd1);
        @(negedge clk);
        check("mid_r6",        regs[6],         R1_VAL);
        check("mid_idle_done", 32'(bus.done),   32'd0);

        // Asynchronous clear during LATCH.
        set_req(0, 3'd2, 3'd5);
        @(negedge clk);
        @(negedge clk);
        #2 clr = 1'b0;
        #1;
        check("arst_out_en", 32'(bus.out_en),     32'd0);
        check("arst_in_en",  32'(bus.in_en),      32'd0);
        check("arst_grant",  32'(bus.grant),      32'd0);
        check("arst_busy",   32'(bus.busy),       32'd0);
        check("arst_count",  32'(bus.xfer_count), 32'd0);
        bus.req = '0;
        @(negedge clk);
        #2 clr = 1'b1;
        @(negedge clk);
        set_req(2, 3'd0, 3'd7);
        @(negedge clk);
        check("arst_after_grant", 32'(bus.grant),      32'h04);
        check("arst_after_count", 32'(bus.xfer_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("arst_after_done", 32'(bus.done), 32'd1);
        drop_req(2);
        @(negedge clk);

        // Random requesters: each holds its request until it sees done with its grant bit.
        pulse_reset();
        ok_dones = 0;
        pend     = '0;
        issued   = 0;
        cyc      = 0;
        while ((issued < 1000 || pend != '0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (bit_at(pend, i) && bus.done && bit_at(bus.grant, i)) begin
                    pend = pend & ~(NREQ'(1) << i);
                    drop_req(i);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!bit_at(pend, i) && issued < 1000 && $urandom_range(0, 2) == 0) begin
                    set_req(i, SELW'($urandom_range(0, NREG - 1)), SELW'($urandom_range(0, NREG - 1)));
                    pend = pend | (NREQ'(1) << i);
                    issued++;
                end
            end
        end
        check("rand_all_served", 32'(pend), 32'd0);
        repeat (2) @(negedge clk);
        check("rand_count_vs_dones", 32'(bus.xfer_count), 32'(CNTW'(ok_dones)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
